// File: rtl/backscatter_pkg.sv
// backscatter_pkg: shared states and default timing constants for the FM0 backscatter transmitter
package backscatter_pkg;
  typedef enum logic [1:0] {IDLE, PRE, DATA, TAIL} state_t;
  localparam int CLK_HZ = 39_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int HALF_BIT_DEF = 195;
  localparam logic [3:0] PREAMBLE_DEF = 4'b1101;
endpackage

// File: rtl/bs_half_bit_timer.sv
// bs_half_bit_timer: half-bit counter giving strobes on the last cycle before mid-bit and before the next bit
module bs_half_bit_timer #(
  parameter int HALF_BIT = 195
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_start,
  output logic mid_bit
);
  localparam int CW = $clog2(HALF_BIT);
  logic [CW-1:0] half_cnt;
  logic half_sel;
  logic last;
  assign last = half_cnt == CW'(HALF_BIT - 1);
  assign mid_bit = run && last && !half_sel;
  assign bit_start = run && last && half_sel;
  // free-running half-bit count while run is high, held at zero otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      half_cnt <= '0;
      half_sel <= 1'b0;
    end else if (!run) begin
      half_cnt <= '0;
      half_sel <= 1'b0;
    end else if (last) begin
      half_cnt <= '0;
      half_sel <= ~half_sel;
    end else
      half_cnt <= half_cnt + 1'b1;
endmodule

// File: rtl/backscatter_fm0_tx.sv
// backscatter_fm0_tx: FM0 frame encoder (preamble, payload MSB-first, dummy-1 tail) driving the RF switch
module backscatter_fm0_tx
  import backscatter_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEF,
  parameter int PAYLOAD_W = 16,
  parameter int PRE_W = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(PREAMBLE_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic                 busy,
  output logic                 done,
  output logic                 sig,
  output logic                 ctrl1
);
  localparam int SW = PRE_W + PAYLOAD_W;
  localparam int BW = $clog2((PAYLOAD_W > PRE_W ? PAYLOAD_W : PRE_W) + 1);
  state_t state, state_n;
  logic [SW-1:0] sreg, sreg_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic level, level_n, done_n, cur_bit;
  logic bit_start, mid_bit;
  bs_half_bit_timer #(.HALF_BIT(HALF_BIT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .run(state != IDLE),
    .bit_start(bit_start),
    .mid_bit(mid_bit)
  );
  // preamble and payload share one shift register so the current bit is always its MSB
  assign cur_bit = state == TAIL ? 1'b1 : sreg[SW-1];
  assign sig = level;
  assign busy = state != IDLE;
  assign ctrl1 = busy;
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sreg <= '0;
      bit_cnt <= '0;
      level <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      bit_cnt <= bit_cnt_n;
      level <= level_n;
      done <= done_n;
    end
  // next state: strobes fire on the cycle before a boundary so the level flips exactly on it
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    bit_cnt_n = bit_cnt;
    level_n = level;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (start && !abort) begin
        state_n = PRE;
        sreg_n = {PREAMBLE, payload};
        bit_cnt_n = '0;
        level_n = 1'b1;
      end
    end else if (abort) begin
      state_n = IDLE;
      bit_cnt_n = '0;
      level_n = 1'b0;
    end else if (mid_bit)
      level_n = cur_bit ? level : ~level;
    else if (bit_start) begin
      level_n = ~level;
      sreg_n = sreg << 1;
      bit_cnt_n = bit_cnt + 1'b1;
      if (state == PRE && bit_cnt == BW'(PRE_W - 1)) begin
        state_n = DATA;
        bit_cnt_n = '0;
      end
      if (state == DATA && bit_cnt == BW'(PAYLOAD_W - 1)) begin
        state_n = TAIL;
        bit_cnt_n = '0;
      end
      if (state == TAIL) begin
        state_n = IDLE;
        level_n = 1'b0;
        done_n = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_backscatter_fm0_tx.sv
// tb_backscatter_fm0_tx: directed self-checking bench for the FM0 frame encoder
module tb_backscatter_fm0_tx;
  localparam int H = 4;
  localparam int NB = 21;
  localparam int FL = NB * 2 * H;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [15:0] payload = '0;
  logic busy, done, sig, ctrl1;
  int n_chk = 0;
  int n_fail = 0;
  int tg;
  logic exp_sig [FL];

  always #5 clk = ~clk;

  backscatter_fm0_tx #(.HALF_BIT(H), .PAYLOAD_W(16), .PRE_W(4), .PREAMBLE(4'b1101)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .payload(payload),
    .busy(busy), .done(done), .sig(sig), .ctrl1(ctrl1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void build(input logic [15:0] pl);
    logic [20:0] bits;
    logic lv;
    bits = {4'b1101, pl, 1'b1};
    lv = 1'b0;
    for (int b = 0; b < NB; b++) begin
      lv = ~lv;
      for (int c = 0; c < 2 * H; c++) begin
        if (c == H && !bits[NB-1-b]) lv = ~lv;
        exp_sig[b*2*H+c] = lv;
      end
    end
  endfunction

  task automatic frame(input logic [15:0] pl, input bit issue, input bit pulses, input bit chain,
                       input logic [15:0] next_pl, input string tag, output int toggles);
    logic prev;
    build(pl);
    toggles = 0;
    prev = 1'b0;
    if (issue) begin
      payload = pl;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    for (int k = 0; k < FL; k++) begin
      check($sformatf("%s k=%0d {done,busy,ctrl1,sig}", tag, k), {done, busy, ctrl1, sig}, {3'b011, exp_sig[k]});
      if (k >= 32 && k < 160 && sig !== prev) toggles++;
      prev = sig;
      start = pulses && (k == 10 || k == 50 || k == 90);
      if (pulses) payload = 16'($urandom);
      tick;
    end
    start = 1'b0;
    check({tag, " done cycle"}, {done, busy, ctrl1, sig}, 4'b1000);
    if (chain) begin
      payload = next_pl;
      start = 1'b1;
      tick;
      start = 1'b0;
    end else begin
      tick;
      check({tag, " after done"}, {done, busy, ctrl1, sig}, 4'b0000);
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle %0d", i), {done, busy, ctrl1, sig}, 4'b0000);
      tick;
    end
    frame(16'hA5F0, 1, 0, 0, 16'h0, "a5f0", tg);
    frame(16'h0000, 1, 0, 0, 16'h0, "zeros", tg);
    check("zeros toggles", tg, 32);
    frame(16'hFFFF, 1, 0, 0, 16'h0, "ones", tg);
    check("ones toggles", tg, 16);
    frame(16'h1234, 1, 1, 1, 16'h8001, "ignore", tg);
    frame(16'h8001, 0, 0, 0, 16'h0, "chain", tg);
    payload = 16'hC3C3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    check("pre-abort busy", {busy, ctrl1}, 2'b11);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort outputs", {done, busy, ctrl1, sig}, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort quiet %0d", i), {done, busy}, 2'b00);
      tick;
    end
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("start+abort %0d", i), {done, busy, ctrl1, sig}, 4'b0000);
      tick;
    end
    payload = 16'hA5F0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (50) tick;
    check("mid-data busy", {busy, ctrl1}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async reset", {done, busy, ctrl1, sig}, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check("post reset idle", {done, busy, ctrl1, sig}, 4'b0000);
    frame(16'hA5F0, 1, 0, 0, 16'h0, "after reset", tg);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/backscatter_fm0_tx.md
Name: backscatter_fm0_tx

Overview:
- FM0 (bi-phase space) frame encoder that drives the backscatter RF switch.
- Clocked by the 39 MHz PLL output `c1` that the backscatter top brings out.
- Takes a latched payload word and emits a framed FM0 waveform on `sig`: fixed preamble, payload MSB-first, then one dummy-1 terminator.
- `ctrl1` enables the antenna switch for the whole frame. `done` and `busy` let the top (key-triggered) sequence frames.

Parameters:
- HALF_BIT, 195, clk cycles per half bit; 39 MHz / 390 gives 100 kbps. Legal range ≥2.
- PAYLOAD_W, 16, payload width in bits.
- PRE_W, 4, preamble width in bits.
- PREAMBLE, 4'b1101, preamble pattern, sent MSB first.

Ports:
- clk  in  1  39 MHz PLL clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous frame kill
- payload  in  PAYLOAD_W  frame data; latched on an accepted start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a frame completes normally
- sig  out  1  FM0 waveform to the RF switch
- ctrl1  out  1  antenna-switch enable

Behaviour:
- Reset/interface: one clock, `clk`. Reset `rst_n` is asynchronous, active-low. Under reset:
  - state=IDLE
  - sig=0, ctrl1=0, busy=0, done=0
  - level=0, counters=0, shift register=0
- States: IDLE → PRE → DATA → TAIL → IDLE.
- Accepting a frame: in IDLE, start=1 and abort=0 at edge t. Then:
  - payload is latched into the shift register at t.
  - At t+1: state=PRE, busy=1, ctrl1=1.
  - The first bit boundary is applied at t+1: level inverts, so sig=1 from level 0.
- Bit timing:
  - half_cnt counts 0..HALF_BIT-1; half_sel selects first or second half.
  - Each bit lasts exactly 2*HALF_BIT cycles.
- FM0 rules:
  - At every bit start, level inverts.
  - At mid-bit (start of the second half), level inverts again only if the current bit is 0.
  - sig = level, registered, with no extra latency beyond this.
- Bit sequencing:
  - PRE sends PREAMBLE[PRE_W-1] down to PREAMBLE[0].
  - DATA sends payload[PAYLOAD_W-1] down to payload[0]; a bit counter selects the bit.
  - TAIL sends one bit of value 1.
- Frame end: after the TAIL bit's final cycle:
  - next cycle: state=IDLE, sig=0, ctrl1=0, busy=0, done=1 for exactly one cycle.
  - Internal level resets to 0, so every frame starts identically.
  - Frame length = (PRE_W+PAYLOAD_W+1)*2*HALF_BIT cycles with ctrl1=1; with defaults that is 8190 cycles.
- Start while busy: ignored, with no queuing.
- A start in the same cycle done is asserted is accepted, because state is already IDLE. Back-to-back frames are therefore separated by exactly 1 IDLE cycle.
- Abort in any non-IDLE state: next cycle goes to IDLE with sig=0, ctrl1=0, busy=0, done=0.
- start and abort together in IDLE: abort wins and no frame starts.
- Payload changes while busy: no effect.
- Asynchronous reset mid-frame: outputs drop to their reset values immediately, with no done pulse.

Decomposition:
- Package backscatter_pkg holds:
  - state enum {IDLE, PRE, DATA, TAIL}
  - default constants CLK_HZ=39_000_000, BIT_RATE=100_000, HALF_BIT_DEF=195
  - the default preamble constant
- One sub-module, bs_half_bit_timer:
  - Parameter HALF_BIT.
  - Inputs clk, rst_n, run. Outputs bit_start and mid_bit strobes.
  - Free-running while run=1; cleared while run=0.
- The FSM, shift register and level logic stay in the parent.

Test Plan (HALF_BIT=4, PAYLOAD_W=16, PRE_W=4, PREAMBLE=4'b1101):
- Reset release then idle 20 cycles → sig=0, ctrl1=0, busy=0, done=0 throughout.
- start with payload=16'hA5F0 → preamble on sig = 8×1, 8×0, 4×1+4×0, 8×1. Then payload bits MSB-first per FM0. Then tail = 8 cycles of constant level. ctrl1=1 for exactly 168 cycles. done pulses once on the cycle after, with sig=0.
- Payload 16'h0000 → every bit shows a mid-bit transition, i.e. sig toggles every 4 cycles through DATA. Payload 16'hFFFF → toggles every 8 cycles only.
- start pulsed at cycles 10, 50 and 90 of a frame → all ignored; exactly one done. New start on the done cycle → second frame begins with ctrl1 low for exactly 1 cycle.
- abort at cycle 30 of a frame → next cycle sig=0, ctrl1=0, busy=0, no done. start+abort together in IDLE → busy stays 0.
- rst_n asserted mid-DATA → outputs zero asynchronously. After release, a new start produces a frame identical to the reset-fresh case.
